// File: rtl/pc_stack_unit.sv
// Program counter with absolute jumps, PC-relative branches and a hardware
// return-address stack for CALL/RET, with sticky overflow/underflow flags.
module pc_stack_unit #(
    parameter int unsigned              ADDR_W      = 8,
    parameter int unsigned              STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0]        RESET_ADDR  = '0,
    localparam int unsigned             IDX_W       = $clog2(STACK_DEPTH),
    localparam int unsigned             SP_W        = IDX_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [2:0]        op,
    input  logic              cond,
    input  logic [ADDR_W-1:0] target,
    input  logic [ADDR_W-1:0] offset,
    input  logic              err_clr,
    output logic [ADDR_W-1:0] pc_addr,
    output logic [SP_W-1:0]   sp,
    output logic              stack_full,
    output logic              stack_empty,
    output logic              overflow_err,
    output logic              underflow_err
);

    localparam logic [2:0] OP_INC    = 3'd0;
    localparam logic [2:0] OP_JUMP   = 3'd1;
    localparam logic [2:0] OP_BRANCH = 3'd2;
    localparam logic [2:0] OP_CALL   = 3'd3;
    localparam logic [2:0] OP_RET    = 3'd4;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic [ADDR_W-1:0] stack_q [STACK_DEPTH];

    logic [ADDR_W-1:0] pc_inc;
    logic [SP_W-1:0]   sp_dec;
    logic              push_en;
    logic              full;
    logic              empty;

    assign pc_inc = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
    assign sp_dec = sp_q - {{(SP_W-1){1'b0}}, 1'b1};
    assign full   = (sp_q == SP_W'(STACK_DEPTH));
    assign empty  = (sp_q == '0);

    always_comb begin
        pc_d    = pc_q;
        sp_d    = sp_q;
        // A new error on this edge overrides a simultaneous clear.
        ovf_d   = ovf_q & ~err_clr;
        unf_d   = unf_q & ~err_clr;
        push_en = 1'b0;
        if (en) begin
            case (op)
                OP_INC:    pc_d = pc_inc;
                OP_JUMP:   pc_d = target;
                OP_BRANCH: pc_d = cond ? (pc_q + offset) : pc_inc;
                OP_CALL: begin
                    if (full) begin
                        ovf_d = 1'b1;
                    end else begin
                        push_en = 1'b1;
                        sp_d    = sp_q + {{(SP_W-1){1'b0}}, 1'b1};
                        pc_d    = target;
                    end
                end
                OP_RET: begin
                    if (empty) begin
                        unf_d = 1'b1;
                    end else begin
                        sp_d = sp_dec;
                        pc_d = stack_q[sp_dec[IDX_W-1:0]];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q  <= RESET_ADDR;
            sp_q  <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            sp_q  <= sp_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Stack contents are don't-care after reset, so no reset term here.
    always_ff @(posedge clk) begin
        if (push_en) begin
            stack_q[sp_q[IDX_W-1:0]] <= pc_inc;
        end
    end

    assign pc_addr       = pc_q;
    assign sp            = sp_q;
    assign stack_full    = full;
    assign stack_empty   = empty;
    assign overflow_err  = ovf_q;
    assign underflow_err = unf_q;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed bench for pc_stack_unit (ADDR_W=8, STACK_DEPTH=4, RESET_ADDR=0x10).
module tb_pc_stack_unit;

    localparam logic [2:0] INC = 3'd0, JUMP = 3'd1, BRANCH = 3'd2,
                           CALL = 3'd3, RET = 3'd4, HOLD = 3'd5;

    logic       clk;
    logic       rst;
    logic       en;
    logic [2:0] op;
    logic       cond;
    logic [7:0] target;
    logic [7:0] offset;
    logic       err_clr;
    logic [7:0] pc_addr;
    logic [2:0] sp;
    logic       stack_full;
    logic       stack_empty;
    logic       overflow_err;
    logic       underflow_err;

    int tests_run = 0;
    int tests_failed = 0;

    pc_stack_unit #(
        .ADDR_W      (8),
        .STACK_DEPTH (4),
        .RESET_ADDR  (8'h10)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .op            (op),
        .cond          (cond),
        .target        (target),
        .offset        (offset),
        .err_clr       (err_clr),
        .pc_addr       (pc_addr),
        .sp            (sp),
        .stack_full    (stack_full),
        .stack_empty   (stack_empty),
        .overflow_err  (overflow_err),
        .underflow_err (underflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one operation, clock it, and return 1 time unit after the edge.
    task automatic step(input logic [2:0] o, input logic [7:0] tgt, input logic [7:0] off,
                        input logic c, input logic e, input logic clr);
        op      = o;
        target  = tgt;
        offset  = off;
        cond    = c;
        en      = e;
        err_clr = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; op = HOLD; cond = 1'b0;
        target = 8'h00; offset = 8'h00; err_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pc", pc_addr, 8'h10);
        check("rst_sp", sp, 3'd0);
        check("rst_empty", stack_empty, 1'b1);
        check("rst_full", stack_full, 1'b0);
        check("rst_ovf", overflow_err, 1'b0);
        check("rst_unf", underflow_err, 1'b0);
        rst = 1'b0;

        step(INC, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0); check("inc1", pc_addr, 8'h11);
        step(INC, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0); check("inc2", pc_addr, 8'h12);
        step(INC, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0); check("inc3", pc_addr, 8'h13);

        #2 rst = 1'b1;
        #1 check("async_rst_pc", pc_addr, 8'h10);
        @(posedge clk); #1;
        rst = 1'b0;

        step(RET, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        check("unf_pc", pc_addr, 8'h10);
        check("unf_flag", underflow_err, 1'b1);
        check("unf_sp", sp, 3'd0);
        step(INC, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        check("unf_inc_pc", pc_addr, 8'h11);
        check("unf_sticky", underflow_err, 1'b1);
        step(HOLD, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        check("unf_clr_noen", underflow_err, 1'b0);
        check("unf_clr_pc", pc_addr, 8'h11);

        step(JUMP, 8'hFE, 8'h00, 1'b0, 1'b1, 1'b0); check("jump_fe", pc_addr, 8'hFE);
        step(INC, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);  check("wrap_ff", pc_addr, 8'hFF);
        step(INC, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);  check("wrap_00", pc_addr, 8'h00);
        for (int i = 0; i < 5; i++) begin
            step(JUMP, 8'h40, 8'h00, 1'b0, 1'b0, 1'b0);
            check("stall_pc", pc_addr, 8'h00);
        end

        step(JUMP, 8'h20, 8'h00, 1'b0, 1'b1, 1'b0);   check("jump_20", pc_addr, 8'h20);
        step(BRANCH, 8'h00, 8'hFC, 1'b1, 1'b1, 1'b0); check("br_back", pc_addr, 8'h1C);
        step(BRANCH, 8'h00, 8'h05, 1'b0, 1'b1, 1'b0); check("br_nt", pc_addr, 8'h1D);
        step(BRANCH, 8'h00, 8'h05, 1'b1, 1'b1, 1'b0); check("br_fwd", pc_addr, 8'h22);
        step(JUMP, 8'hFE, 8'h00, 1'b0, 1'b1, 1'b0);
        step(BRANCH, 8'h00, 8'h03, 1'b1, 1'b1, 1'b0); check("br_wrap", pc_addr, 8'h01);

        step(JUMP, 8'h05, 8'h00, 1'b0, 1'b1, 1'b0);
        step(CALL, 8'h80, 8'h00, 1'b0, 1'b1, 1'b0);
        check("call1_pc", pc_addr, 8'h80); check("call1_sp", sp, 3'd1);
        step(CALL, 8'hA0, 8'h00, 1'b0, 1'b1, 1'b0);
        check("call2_pc", pc_addr, 8'hA0); check("call2_sp", sp, 3'd2);
        step(RET, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        check("ret1_pc", pc_addr, 8'h81); check("ret1_sp", sp, 3'd1);
        step(RET, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        check("ret2_pc", pc_addr, 8'h06); check("ret2_sp", sp, 3'd0);
        check("ret2_empty", stack_empty, 1'b1);

        step(CALL, 8'h10, 8'h00, 1'b0, 1'b1, 1'b0);
        check("fill1_empty", stack_empty, 1'b0);
        step(CALL, 8'h20, 8'h00, 1'b0, 1'b1, 1'b0);
        step(CALL, 8'h30, 8'h00, 1'b0, 1'b1, 1'b0);
        check("fill3_full", stack_full, 1'b0);
        step(CALL, 8'h40, 8'h00, 1'b0, 1'b1, 1'b0);
        check("fill4_pc", pc_addr, 8'h40); check("fill4_sp", sp, 3'd4);
        check("fill4_full", stack_full, 1'b1);
        check("fill4_ovf", overflow_err, 1'b0);
        step(CALL, 8'h33, 8'h00, 1'b0, 1'b1, 1'b0);
        check("ovf_pc", pc_addr, 8'h40); check("ovf_sp", sp, 3'd4);
        check("ovf_flag", overflow_err, 1'b1);
        step(CALL, 8'h33, 8'h00, 1'b0, 1'b1, 1'b1);
        check("ovf_set_wins", overflow_err, 1'b1);
        check("ovf_set_wins_pc", pc_addr, 8'h40);
        step(HOLD, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
        check("ovf_clr", overflow_err, 1'b0);
        check("hold_pc", pc_addr, 8'h40);
        step(3'd6, 8'h55, 8'h01, 1'b1, 1'b1, 1'b0);
        check("rsvd_pc", pc_addr, 8'h40); check("rsvd_sp", sp, 3'd4);

        step(RET, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0); check("pop4_pc", pc_addr, 8'h31);
        step(RET, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0); check("pop3_pc", pc_addr, 8'h21);
        step(RET, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0); check("pop2_pc", pc_addr, 8'h11);
        step(RET, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0); check("pop1_pc", pc_addr, 8'h07);
        check("pop1_sp", sp, 3'd0);
        check("pop_no_unf", underflow_err, 1'b0);

        step(CALL, 8'h50, 8'h00, 1'b0, 1'b1, 1'b0); check("b2b_call", pc_addr, 8'h50);
        step(RET, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);  check("b2b_ret", pc_addr, 8'h08);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
